phy_rx_lane: RTL

Single-lane serial receiver for the PHY link: deserializes the MSB-first bitstream produced by the PHY transmitter on `clk_8f` and finds byte alignment on the comma byte 8'hBC. It declares the link active after a run of consecutive aligned commas. Once active, it delivers each received byte with a valid flag; the transmitter's idle fill (BC) is reported with valid deasserted. Two instances sit after the serializer outputs, one per lane, and feed the lane unstriping logic.

---
 rtl/phy_rx_lane.sv | 120 ++++++++++++
 1 files changed

// File: rtl/phy_rx_lane.sv
// phy_rx_lane: single-lane serial receiver.
// Deserializes an MSB-first bitstream on clk_8f, aligns on the comma byte,
// declares the link active after LOCK_COUNT consecutive aligned commas and
// then delivers each received byte, flagging comma idle fill as not valid.
module phy_rx_lane #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       enable,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_COUNT  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    state_t      state;
    logic [7:0]  sr;
    logic [2:0]  bit_cnt;
    logic [3:0]  bc_cnt;

    logic [7:0]  nsr;
    logic        boundary;
    logic        nsr_is_comma;
    logic [3:0]  bc_cnt_inc;

    // Word as it will look after this edge's bit is shifted in; every
    // comparison (search, lock counting, data capture) is made on it so the
    // byte is recognised on the same edge that samples its last bit.
    always_comb begin
        nsr          = {sr[6:0], data_in};
        boundary     = (bit_cnt == 3'd7);
        nsr_is_comma = (nsr == COMMA);
        bc_cnt_inc   = bc_cnt + 4'd1;
    end

    // Link-up is a pure decode of the state, no extra register stage.
    assign active = (state == ST_ACTIVE);

    // Alignment FSM, deserializer and registered outputs. A disabled edge
    // freezes everything; only the strobe is dropped so it stays a pulse.
    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state       <= ST_SEARCH;
            sr          <= 8'h00;
            bit_cnt     <= 3'd0;
            bc_cnt      <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
        end else if (!enable) begin
            byte_strobe <= 1'b0;
        end else begin
            sr          <= nsr;
            byte_strobe <= 1'b0;
            case (state)
                // Slide one bit at a time until a comma shows up at any offset;
                // that edge becomes the byte alignment reference.
                ST_SEARCH: begin
                    bit_cnt <= 3'd0;
                    if (nsr_is_comma) begin
                        state  <= ST_COUNT;
                        bc_cnt <= 4'd1;
                    end else begin
                        bc_cnt <= 4'd0;
                    end
                end
                // Confirm alignment: every boundary must carry another comma.
                // A non-comma means the first hit was false, so resume search.
                ST_COUNT: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (nsr_is_comma) begin
                            if (bc_cnt != LOCK_CNT) begin
                                bc_cnt <= bc_cnt_inc;
                            end
                            if (bc_cnt_inc == LOCK_CNT) begin
                                state <= ST_ACTIVE;
                            end
                        end else begin
                            state   <= ST_SEARCH;
                            bc_cnt  <= 4'd0;
                            bit_cnt <= 3'd0;
                        end
                    end
                end
                // Locked: deliver each byte; commas are idle fill and only
                // clear valid while the last data byte stays on data_out.
                ST_ACTIVE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        byte_strobe <= 1'b1;
                        if (nsr_is_comma) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_out  <= nsr;
                            valid_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_SEARCH;
                    bit_cnt <= 3'd0;
                    bc_cnt  <= 4'd0;
                end
            endcase
        end
    end

endmodule
